// File: rtl/cic_decimator.sv
// CIC decimator: N integrators at the input rate, decimate by DEC, N combs (delay DIFF_DELAY), then output quantisation.
// Latency: STAGES+2 cycles from the edge that samples the DEC-th accepted din_valid to dout_valid.
// Backpressure: none. din_valid may be high every cycle, the comb pipeline never stalls, and dout is held between strobes.
//
// Ports:
//   clk_in, rst   : clock and synchronous active-high reset
//   din/din_valid : signed input sample and its qualifier
//   dout          : signed decimated output
//   dout_valid    : one-cycle strobe for each output sample
module cic_decimator #(
    parameter int DIN_WIDTH  = 16,
    parameter int ACC_WIDTH  = 25,
    parameter int DOUT_WIDTH = 16,
    parameter int STAGES     = 3,
    parameter int DEC        = 8,
    parameter int DIFF_DELAY = 1,
    parameter int ROUND      = 0
) (
    input  logic                         clk_in,
    input  logic                         rst,
    input  logic signed [DIN_WIDTH-1:0]  din,
    input  logic                         din_valid,
    output logic signed [DOUT_WIDTH-1:0] dout,
    output logic                         dout_valid
);

    localparam int               CNT_W   = $clog2(DEC);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEC - 1);
    localparam int               SHIFT   = ACC_WIDTH - DOUT_WIDTH;
    localparam int               EXT     = ACC_WIDTH - DIN_WIDTH;

    generate
        if (ACC_WIDTH < DIN_WIDTH + STAGES * $clog2(DEC * DIFF_DELAY)) begin : g_chk_acc
            $error("cic_decimator: ACC_WIDTH too small for the filter gain");
        end
        if (DOUT_WIDTH > ACC_WIDTH) begin : g_chk_dout
            $error("cic_decimator: DOUT_WIDTH must not exceed ACC_WIDTH");
        end
        if (DEC < 2) begin : g_chk_dec
            $error("cic_decimator: DEC must be at least 2");
        end
        if (DIFF_DELAY != 1 && DIFF_DELAY != 2) begin : g_chk_dd
            $error("cic_decimator: DIFF_DELAY must be 1 or 2");
        end
    endgenerate

    logic signed [ACC_WIDTH-1:0] din_ext;
    logic signed [ACC_WIDTH-1:0] integ    [STAGES];
    logic [CNT_W-1:0]            cnt;
    logic                        cap_pend;
    // Index 0 is the captured decimated sample. Index k holds the output of comb stage k.
    logic signed [ACC_WIDTH-1:0] comb_dat [STAGES+1];
    logic                        comb_vld [STAGES+1];
    logic signed [ACC_WIDTH-1:0] dly      [STAGES][DIFF_DELAY];
    logic signed [DOUT_WIDTH-1:0] q_dat;

    assign din_ext = {{EXT{din[DIN_WIDTH-1]}}, din};

    // Integrators wrap modulo 2^ACC_WIDTH on purpose. Each stage adds the
    // previous stage's value from before this update, so the chain is pipelined.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                integ[k] <= '0;
            end
            cnt      <= '0;
            cap_pend <= 1'b0;
        end else begin
            cap_pend <= 1'b0;
            if (din_valid) begin
                integ[0] <= integ[0] + din_ext;
                for (int k = 1; k < STAGES; k++) begin
                    integ[k] <= integ[k] + integ[k-1];
                end
                if (cnt == CNT_MAX) begin
                    cnt      <= '0;
                    cap_pend <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    // The capture happens one cycle after the wrap, so it picks up the final
    // integrator value after that valid has been applied.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            for (int k = 0; k <= STAGES; k++) begin
                comb_dat[k] <= '0;
                comb_vld[k] <= 1'b0;
            end
            for (int k = 0; k < STAGES; k++) begin
                for (int j = 0; j < DIFF_DELAY; j++) begin
                    dly[k][j] <= '0;
                end
            end
        end else begin
            comb_vld[0] <= cap_pend;
            if (cap_pend) begin
                comb_dat[0] <= integ[STAGES-1];
            end
            for (int k = 0; k < STAGES; k++) begin
                comb_vld[k+1] <= comb_vld[k];
                if (comb_vld[k]) begin
                    comb_dat[k+1] <= comb_dat[k] - dly[k][DIFF_DELAY-1];
                    dly[k][0]     <= comb_dat[k];
                    for (int j = 1; j < DIFF_DELAY; j++) begin
                        dly[k][j] <= dly[k][j-1];
                    end
                end
            end
        end
    end

    generate
        if (SHIFT == 0) begin : g_pass
            assign q_dat = comb_dat[STAGES];
        end else if (ROUND == 0) begin : g_trunc
            assign q_dat = DOUT_WIDTH'(comb_dat[STAGES] >>> SHIFT);
        end else begin : g_round
            localparam logic [ACC_WIDTH:0] HALF = {{ACC_WIDTH{1'b0}}, 1'b1} << (SHIFT - 1);
            logic signed [ACC_WIDTH:0] rnd_sum;
            // The sum is one bit wider than the accumulator. Adding a positive
            // half-LSB can only overflow upward, so only positive saturation is needed.
            assign rnd_sum = $signed({comb_dat[STAGES][ACC_WIDTH-1], comb_dat[STAGES]}) + $signed(HALF);
            assign q_dat   = (rnd_sum[ACC_WIDTH] != rnd_sum[ACC_WIDTH-1])
                           ? {1'b0, {(DOUT_WIDTH-1){1'b1}}}
                           : DOUT_WIDTH'(rnd_sum >>> SHIFT);
        end
    endgenerate

    always_ff @(posedge clk_in) begin
        if (rst) begin
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            dout_valid <= comb_vld[STAGES];
            if (comb_vld[STAGES]) begin
                dout <= q_dat;
            end
        end
    end

endmodule
